// File: rtl/spi_arbiter.sv
// -----------------------------------------------------------------------------
// spi_arbiter
//
// Shares one SPI master between nreq requesters using round-robin arbitration.
// A grant covers one whole transaction. The transaction runs in this order:
// packet size to the master, then the outgoing word to the master, then the
// word returned by the master, then delivery of that word to the requester.
// The master's single active-low chip select is routed onto the cs bit of the
// granted requester. Every other cs bit is held high.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   req_val/rdy     per-requester transaction handshake (nreq bits each)
//   req_msg         flattened outgoing words; requester i at [i*nbits +: nbits]
//   req_size        flattened packet sizes;   requester i at [i*SW +: SW]
//   resp_val/rdy    per-requester response handshake
//   resp_msg        returned word, shared by all requesters
//   spi_size_*      packet size channel to the master
//   spi_recv_*      outgoing word channel to the master
//   spi_send_*      returned word channel from the master
//   spi_cs          master chip select (active low)
//   cs              per-device chip selects (active low)
// -----------------------------------------------------------------------------
module spi_arbiter #(
    parameter int unsigned nbits = 34,
    parameter int unsigned nreq  = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,

    input  logic [nreq-1:0]                        req_val,
    output logic [nreq-1:0]                        req_rdy,
    input  logic [nreq*nbits-1:0]                  req_msg,
    input  logic [nreq*($clog2(nbits)+1)-1:0]      req_size,

    output logic [nreq-1:0]                        resp_val,
    input  logic [nreq-1:0]                        resp_rdy,
    output logic [nbits-1:0]                       resp_msg,

    output logic                                   spi_size_val,
    input  logic                                   spi_size_rdy,
    output logic [$clog2(nbits):0]                 spi_size_msg,

    output logic                                   spi_recv_val,
    input  logic                                   spi_recv_rdy,
    output logic [nbits-1:0]                       spi_recv_msg,

    input  logic                                   spi_send_val,
    output logic                                   spi_send_rdy,
    input  logic [nbits-1:0]                       spi_send_msg,

    input  logic                                   spi_cs,
    output logic [nreq-1:0]                        cs
);

    localparam int unsigned SW = $clog2(nbits) + 1;
    localparam int unsigned PW = $clog2(nreq);

    localparam logic [SW-1:0] SIZE_MAX = SW'(nbits);
    localparam logic [PW-1:0] LAST_REQ = PW'(nreq - 1);
    localparam logic [PW:0]   NREQ_W   = (PW + 1)'(nreq);

    typedef enum logic [2:0] {
        IDLE,
        SIZE,
        XFER,
        WAIT,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q,   ptr_d;
    logic [PW-1:0]    grant_q, grant_d;
    logic [nbits-1:0] msg_q,   msg_d;
    logic [nbits-1:0] resp_q,  resp_d;
    logic [SW-1:0]    size_q,  size_d;

    logic             win_valid;
    logic [PW-1:0]    win_idx;
    logic [PW:0]      cand;

    // A size of zero, or one wider than the word, means a full word.
    function automatic logic [SW-1:0] clamp_size(input logic [SW-1:0] s);
        if ((s == '0) || (s > SIZE_MAX)) begin
            return SIZE_MAX;
        end
        return s;
    endfunction

    // Round-robin search starting at ptr_q. The candidate sum has one extra bit
    // so that the wrap is a single subtraction, even when nreq is not a power of two.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < nreq; k++) begin
            cand = {1'b0, ptr_q} + (PW + 1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!win_valid && req_val[cand[PW-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[PW-1:0];
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        msg_d        = msg_q;
        resp_d       = resp_q;
        size_d       = size_q;

        req_rdy      = '0;
        resp_val     = '0;
        spi_size_val = 1'b0;
        spi_recv_val = 1'b0;
        spi_send_rdy = 1'b0;
        cs           = '1;

        if (state_q != IDLE) begin
            cs[grant_q] = spi_cs;
        end

        unique case (state_q)
            IDLE: begin
                // The winner has req_val high by construction, so offering
                // rdy to it always fires.
                if (win_valid && !reset) begin
                    req_rdy[win_idx] = 1'b1;
                    state_d          = SIZE;
                    grant_d          = win_idx;
                    msg_d            = req_msg[win_idx*nbits +: nbits];
                    size_d           = clamp_size(req_size[win_idx*SW +: SW]);
                end
            end

            SIZE: begin
                spi_size_val = 1'b1;
                if (spi_size_rdy) begin
                    state_d = XFER;
                end
            end

            XFER: begin
                spi_recv_val = 1'b1;
                if (spi_recv_rdy) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                spi_send_rdy = 1'b1;
                if (spi_send_val) begin
                    resp_d  = spi_send_msg;
                    state_d = RESP;
                end
            end

            RESP: begin
                resp_val[grant_q] = 1'b1;
                if (resp_rdy[grant_q]) begin
                    state_d = IDLE;
                    ptr_d   = (grant_q == LAST_REQ) ? '0 : grant_q + PW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            msg_q   <= '0;
            resp_q  <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            msg_q   <= msg_d;
            resp_q  <= resp_d;
            size_q  <= size_d;
        end
    end

    assign spi_size_msg = size_q;
    assign spi_recv_msg = msg_q;
    assign resp_msg     = resp_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_arbiter
//
// Bench for spi_arbiter. The reference model works at the transaction level.
// Each accepted request appends its expected handshakes (size, outgoing word,
// returned word, response) to an event queue. The head of that queue gives
// the only channel that may be active in a cycle.
// -----------------------------------------------------------------------------
module tb_spi_arbiter;

    localparam int unsigned NBITS = 34;
    localparam int unsigned NREQ  = 2;
    localparam int unsigned SW    = $clog2(NBITS) + 1;

    typedef enum int {EV_SIZE, EV_RECV, EV_SEND, EV_RESP} ev_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req_val, req_rdy, resp_val, resp_rdy, cs;
    logic [NREQ*NBITS-1:0]  req_msg;
    logic [NREQ*SW-1:0]     req_size;
    logic [NBITS-1:0]       resp_msg, spi_recv_msg, spi_send_msg;
    logic [SW-1:0]          spi_size_msg;
    logic                   spi_size_val, spi_size_rdy;
    logic                   spi_recv_val, spi_recv_rdy;
    logic                   spi_send_val, spi_send_rdy;
    logic                   spi_cs;

    always #5 clk = ~clk;

    spi_arbiter #(.nbits(NBITS), .nreq(NREQ)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .req_msg      (req_msg),
        .req_size     (req_size),
        .resp_val     (resp_val),
        .resp_rdy     (resp_rdy),
        .resp_msg     (resp_msg),
        .spi_size_val (spi_size_val),
        .spi_size_rdy (spi_size_rdy),
        .spi_size_msg (spi_size_msg),
        .spi_recv_val (spi_recv_val),
        .spi_recv_rdy (spi_recv_rdy),
        .spi_recv_msg (spi_recv_msg),
        .spi_send_val (spi_send_val),
        .spi_send_rdy (spi_send_rdy),
        .spi_send_msg (spi_send_msg),
        .spi_cs       (spi_cs),
        .cs           (cs)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model state
    ev_t              evq[$];
    int unsigned      m_ptr;
    int unsigned      m_grant;
    logic [SW-1:0]    m_size;
    logic [NBITS-1:0] m_msg;
    logic [NBITS-1:0] m_resp;

    // Requester-side pending transactions
    logic [NREQ-1:0]  rv;
    logic [NBITS-1:0] pm [NREQ];
    logic [SW-1:0]    ps [NREQ];

    // Observations taken from the DUT's handshakes
    int obs_grants[$];
    int obs_done;
    int fire_cyc;

    // Stimulus knobs
    int unsigned req_pct;
    int unsigned rdy_pct;
    bit          rand_peers;
    bit          rand_reset;

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int unsigned p);
        int unsigned c;
        for (int unsigned k = 0; k < NREQ; k++) begin
            c = (p + k) % NREQ;
            if (v[c]) return int'(c);
        end
        return -1;
    endfunction

    function automatic logic [SW-1:0] expect_size(input logic [SW-1:0] s);
        int unsigned v;
        v = s;
        if (v == 0 || v > NBITS) return SW'(NBITS);
        return s;
    endfunction

    function automatic logic [SW-1:0] pick_size();
        int unsigned r;
        r = $urandom_range(0, 7);
        case (r)
            0: return '0;
            1: return SW'(NBITS);
            2: return SW'(NBITS + 1);
            3: return '1;
            4: return SW'(1);
            5: return SW'(40);
            default: return SW'($urandom_range(1, (1 << SW) - 1));
        endcase
    endfunction

    function automatic logic [NBITS-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[NBITS-1:0];
    endfunction

    // Runs just before the rising edge: compare outputs, then advance the model
    // across that edge.
    task automatic eval_cycle();
        int              w;
        bit              idle;
        ev_t             k;
        logic [NREQ-1:0] e_rdy, e_rv, e_cs;

        if (reset) begin
            evq.delete();
            m_ptr  = 0;
            m_resp = '0;
            m_size = '0;
            m_msg  = '0;
            return;
        end

        for (int i = 0; i < NREQ; i++) begin
            if (req_val[i] && req_rdy[i]) begin
                obs_grants.push_back(i);
                fire_cyc = cyc;
            end
            if (resp_val[i] && resp_rdy[i]) obs_done++;
        end

        idle = (evq.size() == 0);
        k    = idle ? EV_SIZE : evq[0];
        w    = rr_pick(req_val, m_ptr);

        e_rdy = '0;
        if (idle && w >= 0) e_rdy[w] = 1'b1;
        check_eq("req_rdy", req_rdy, e_rdy);

        check_eq("size_val", spi_size_val, !idle && k == EV_SIZE);
        if (!idle && k == EV_SIZE) check_eq("size_msg", spi_size_msg, m_size);
        check_eq("recv_val", spi_recv_val, !idle && k == EV_RECV);
        if (!idle && k == EV_RECV) check_eq("recv_msg", spi_recv_msg, m_msg);
        check_eq("send_rdy", spi_send_rdy, !idle && k == EV_SEND);

        e_rv = '0;
        if (!idle && k == EV_RESP) e_rv[m_grant] = 1'b1;
        check_eq("resp_val", resp_val, e_rv);
        check_eq("resp_msg", resp_msg, m_resp);

        e_cs = '1;
        if (!idle) e_cs[m_grant] = spi_cs;
        check_eq("cs", cs, e_cs);

        if (idle) begin
            if (w >= 0) begin
                m_grant = w;
                m_size  = expect_size(ps[w]);
                m_msg   = pm[w];
                rv[w]   = 1'b0;
                evq.push_back(EV_SIZE);
                evq.push_back(EV_RECV);
                evq.push_back(EV_SEND);
                evq.push_back(EV_RESP);
            end
        end else begin
            case (k)
                EV_SIZE: if (spi_size_rdy) void'(evq.pop_front());
                EV_RECV: if (spi_recv_rdy) void'(evq.pop_front());
                EV_SEND: if (spi_send_val) begin
                    m_resp = spi_send_msg;
                    void'(evq.pop_front());
                end
                EV_RESP: if (resp_rdy[m_grant]) begin
                    void'(evq.pop_front());
                    m_ptr = (m_grant + 1) % NREQ;
                end
                default: ;
            endcase
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (rand_reset) reset = ($urandom_range(0, 149) == 0);
        for (int i = 0; i < NREQ; i++) begin
            if (!rv[i] && $urandom_range(0, 99) < req_pct) begin
                rv[i] = 1'b1;
                pm[i] = rand_word();
                ps[i] = pick_size();
            end
        end
        if (rand_peers) begin
            spi_size_rdy = ($urandom_range(0, 99) < rdy_pct);
            spi_recv_rdy = ($urandom_range(0, 99) < rdy_pct);
            spi_send_val = ($urandom_range(0, 99) < rdy_pct);
            for (int i = 0; i < NREQ; i++) resp_rdy[i] = ($urandom_range(0, 99) < rdy_pct);
            spi_send_msg = rand_word();
            spi_cs       = ($urandom_range(0, 3) == 0);
        end
        req_val = rv;
        for (int i = 0; i < NREQ; i++) begin
            req_msg[i*NBITS +: NBITS] = pm[i];
            req_size[i*SW +: SW]      = ps[i];
        end
        #1;
        eval_cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          resp_cyc;
        logic [SW-1:0]    seen_size;
        logic [NBITS-1:0] seen_recv;

        reset        = 1'b1;
        rv           = '0;
        req_pct      = 0;
        rdy_pct      = 100;
        rand_peers   = 1'b0;
        rand_reset   = 1'b0;
        spi_size_rdy = 1'b0;
        spi_recv_rdy = 1'b0;
        spi_send_val = 1'b0;
        spi_send_msg = '0;
        spi_cs       = 1'b1;
        resp_rdy     = '0;
        req_val      = '0;
        req_msg      = '0;
        req_size     = '0;
        obs_done     = 0;
        fire_cyc     = -1;
        for (int i = 0; i < NREQ; i++) begin
            pm[i] = '0;
            ps[i] = '0;
        end

        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        check_eq("rst_size_msg", spi_size_msg, 0);
        check_eq("rst_recv_msg", spi_recv_msg, 0);
        check_eq("rst_resp_msg", resp_msg, 0);
        check_eq("rst_cs", cs, 2'b11);
        check_eq("rst_vals", {spi_size_val, spi_recv_val, spi_send_rdy, resp_val, req_rdy}, 0);

        // One transaction from requester 0 with every peer always ready
        spi_size_rdy = 1'b1;
        spi_recv_rdy = 1'b1;
        spi_send_val = 1'b1;
        resp_rdy     = '1;
        spi_send_msg = 34'h1234;
        spi_cs       = 1'b0;
        rv[0]        = 1'b1;
        pm[0]        = 34'h0_DEAD_BEEF;
        ps[0]        = SW'(16);
        fire_cyc     = -1;
        resp_cyc     = -1;
        seen_size    = '0;
        seen_recv    = '0;
        for (int n = 0; n < 12 && resp_cyc < 0; n++) begin
            cycle();
            if (spi_size_val) seen_size = spi_size_msg;
            if (spi_recv_val) seen_recv = spi_recv_msg;
            if (resp_val[0]) resp_cyc = cyc;
        end
        check_eq("d1_latency", resp_cyc - fire_cyc, 4);
        check_eq("d1_size", seen_size, 16);
        check_eq("d1_recv", seen_recv, 34'h0_DEAD_BEEF);
        check_eq("d1_resp_msg", resp_msg, 34'h1234);
        check_eq("d1_cs1", cs[1], 1'b1);
        cycle();

        // Reset while waiting for the master's word
        spi_send_val = 1'b0;
        rv[0]        = 1'b1;
        pm[0]        = rand_word();
        ps[0]        = SW'(8);
        for (int n = 0; n < 20 && !(evq.size() > 0 && evq[0] == EV_SEND); n++) cycle();
        cycle();
        check_eq("reach_wait", spi_send_rdy, 1'b1);
        check_eq("wait_cs0", cs, 2'b10);
        reset = 1'b1;
        cycle();
        reset        = 1'b0;
        spi_send_val = 1'b1;
        rv[1]        = 1'b1;
        pm[1]        = rand_word();
        ps[1]        = '0;
        cycle();
        check_eq("post_rst_cs", cs, 2'b11);
        check_eq("post_rst_vals", {spi_size_val, spi_recv_val, spi_send_rdy, resp_val}, 0);
        check_eq("post_rst_rdy", req_rdy, 2'b10);
        for (int n = 0; n < 20 && evq.size() > 0; n++) cycle();

        // Both requesters continuously pending: grants must alternate
        obs_grants.delete();
        req_pct = 100;
        for (int n = 0; n < 60 && obs_grants.size() < 4; n++) cycle();
        check_eq("alt_count", obs_grants.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < obs_grants.size(); i++) begin
            check_eq("alt_order", obs_grants[i], i % 2);
        end

        // Randomised traffic with stalls, spurious master inputs and resets
        obs_done   = 0;
        req_pct    = 30;
        rdy_pct    = 70;
        rand_peers = 1'b1;
        rand_reset = 1'b1;
        repeat (3000) cycle();
        rand_reset = 1'b0;
        reset      = 1'b0;
        repeat (50) cycle();
        check_eq("progress", obs_done > 100, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares one SPI master (packet-size, recv and send val/rdy interfaces) between nreq independent requesters, each wired to its own chip select.
- Round-robin arbitration. A grant is held for one complete transaction: packet size, then outgoing word, then returned word, then response delivery.
- Sits between the SPI master and the client blocks (e.g. per-device drivers). Routes the master's single cs onto a per-requester cs vector.

Parameters:
- nbits, 34, SPI word width (width of the master recv/send messages)
- nreq, 2, number of requesters and chip selects (≥2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_val  in  nreq  requester i has a transaction
- req_rdy  out  nreq  transaction accepted from requester i
- req_msg  in  nreq*nbits  flattened; requester i at bits [i*nbits +: nbits]
- req_size  in  nreq*SW  flattened packet sizes, SW=$clog2(nbits)+1
- resp_val  out  nreq  returned word valid for requester i
- resp_rdy  in  nreq  requester i accepts response
- resp_msg  out  nbits  returned word, shared by all requesters
- spi_size_val  out  1  packet size to master
- spi_size_rdy  in  1
- spi_size_msg  out  SW
- spi_recv_val  out  1  outgoing word to master
- spi_recv_rdy  in  1
- spi_recv_msg  out  nbits
- spi_send_val  in  1  word returned by master
- spi_send_rdy  out  1
- spi_send_msg  in  nbits
- spi_cs  in  1  master chip select, active low
- cs  out  nreq  per-device chip selects, active low

Behaviour:
- Reset values:
  - all val/rdy outputs 0
  - resp_msg, spi_size_msg and spi_recv_msg 0
  - cs all 1
  - state IDLE
  - RR pointer ptr = 0
- Reset mid-transaction aborts immediately. The state is IDLE the next cycle, with cs all 1 in that cycle.
- Handshake: a transfer fires on a cycle where val && rdy at a rising clk edge. No val depends combinationally on the matching rdy.
- FSM:
  - IDLE:
    - Winner g is the first i with req_val[i]=1, searching ptr, ptr+1, …, wrapping mod nreq.
    - req_rdy[g]=1 combinationally; all other req_rdy are 0.
    - On fire, register g, req_msg[g] and the clamped size, then go to SIZE.
    - With no req_val, stay in IDLE with all req_rdy 0.
  - SIZE: spi_size_val=1 with spi_size_msg = size register. On fire go to XFER.
  - XFER: spi_recv_val=1 with spi_recv_msg = message register. On fire go to WAIT.
  - WAIT: spi_send_rdy=1. On fire, register spi_send_msg and go to RESP.
  - RESP:
    - resp_val[g]=1; resp_msg = registered word.
    - On resp_rdy[g] fire, go to IDLE with ptr = (g+1) mod nreq.
    - resp_rdy of a non-granted requester is ignored.
- Size clamp: a req_size of 0 or greater than nbits is forwarded as nbits. All other values pass unchanged.
- cs:
  - cs[g] = spi_cs in states SIZE, XFER, WAIT and RESP.
  - Every other cs bit, and every cs bit in IDLE, is 1.
  - Only one cs bit can ever be 0 at a time.
- req_rdy is 0 in every state except IDLE, so new requests wait. ptr changes only on a RESP completion.
- Minimum latency from req fire to resp_val is 4 cycles: SIZE, XFER, WAIT and RESP entry with zero-wait peers. Back-to-back transactions incur 1 IDLE cycle.
- resp_msg holds its last value outside RESP. resp_val is 0 outside RESP.
- Inputs from the master are ignored outside their own state, e.g. a spurious spi_send_val in XFER is not captured.

Test Plan:
- Reset, then req_val[0]=1, req_msg=34'h0_DEAD_BEEF, req_size=16, with all peers always ready and spi_send_msg=34'h1234 -> spi_size_msg=16, spi_recv_msg=0xDEADBEEF, resp_val[0] 4 cycles after req fire with resp_msg=0x1234, cs[0] follows spi_cs, cs[1]=1 throughout, ptr becomes 1.
- Both req_val held high for 4 transactions -> grant order 0,1,0,1; req_rdy one-hot and only in IDLE.
- req_size=0, then req_size=40 (nbits=34) -> spi_size_msg=34 both times; req_size=34 -> 34.
- spi_size_rdy, spi_recv_rdy and resp_rdy each stall for 3 cycles -> the FSM holds its state, val stays 1, msg stays stable, no cs change; resp_rdy[1] asserted during the RESP for requester 0 does not complete the transaction.
- reset asserted in WAIT with spi_cs=0 -> next cycle all val/rdy 0 and cs=all 1; a subsequent req from requester 1 is granted first because ptr=0 only picks 1 when req_val[0]=0.
- spi_send_val pulsed during XFER -> not captured; the word captured in WAIT is returned.
